// File: rtl/audio_capture_channel.sv
// Stereo audio capture channel: packs strobed {right,left} samples into a FIFO
// and drains them to memory through a single-outstanding DMA write master.
module audio_capture_channel #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_request,
  input  logic               i_rw,
  input  logic [3:0]         i_address,
  input  logic [31:0]        i_wdata,
  output logic [31:0]        o_rdata,
  output logic               o_ready,
  output logic               o_dma_request,
  output logic               o_dma_rw,
  output logic [31:0]        o_dma_address,
  output logic [31:0]        o_dma_wdata,
  input  logic               i_dma_ready,
  input  logic               i_input_sample_clock,
  input  logic signed [15:0] i_input_sample_left,
  input  logic signed [15:0] i_input_sample_right
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  logic [31:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   occ;
  logic          fifo_empty, fifo_full;
  logic [1:0]    state;
  logic          busy, overflow, abort_pend;
  logic [31:0]   start_addr, sample_count, captured, written, dma_addr;
  logic          serve, cpu_wr, start_cmd, abort_cmd, clear_ovf, flush;
  logic          capture_en, push, drop, launch, accept, pop, done;
  logic [31:0]   read_mux;

  assign o_dma_rw   = 1'b1;
  assign fifo_empty = (occ == '0);
  assign fifo_full  = (occ == (AW+1)'(FIFO_DEPTH));

  always_comb begin
    serve      = i_request && !o_ready;
    cpu_wr     = serve && i_rw;
    start_cmd  = cpu_wr && (i_address == 4'd1) && (i_wdata != '0) && !busy;
    abort_cmd  = cpu_wr && (i_address == 4'd2) && i_wdata[0] && busy;
    clear_ovf  = cpu_wr && (i_address == 4'd2) && i_wdata[1];
    flush      = start_cmd || abort_cmd;
    // Capture halts the moment an abort is accepted, before the flag registers.
    capture_en = i_input_sample_clock && busy && !abort_pend && !abort_cmd &&
                 (captured < sample_count);
    push       = capture_en && !fifo_full;
    drop       = capture_en && fifo_full;
    launch     = (state == ST_IDLE) && !fifo_empty && !i_dma_ready;
    accept     = (state == ST_ISSUE) && i_dma_ready;
    // After an abort flush the in-flight word lives only in o_dma_wdata.
    pop        = accept && !fifo_empty;
    done       = accept && busy && (abort_pend || (written + 32'd1 == sample_count));
    case (i_address)
      4'd0:    read_mux = start_addr;
      4'd1:    read_mux = sample_count - written;
      4'd2:    read_mux = {29'd0, fifo_empty, overflow, busy};
      default: read_mux = '0;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_ready    <= 1'b0;
      o_rdata    <= '0;
      start_addr <= '0;
    end else if (serve) begin
      o_ready <= 1'b1;
      o_rdata <= i_rw ? 32'd0 : read_mux;
      if (cpu_wr && (i_address == 4'd0) && !busy) start_addr <= i_wdata;
    end else if (o_ready && !i_request) begin
      o_ready <= 1'b0;
      o_rdata <= '0;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      busy         <= 1'b0;
      abort_pend   <= 1'b0;
      overflow     <= 1'b0;
      sample_count <= '0;
      captured     <= '0;
      written      <= '0;
      dma_addr     <= '0;
    end else begin
      if (drop)           overflow <= 1'b1;
      else if (clear_ovf) overflow <= 1'b0;
      if (start_cmd) begin
        busy         <= 1'b1;
        sample_count <= i_wdata;
        captured     <= '0;
        written      <= '0;
        dma_addr     <= start_addr;
      end else begin
        if (push) captured <= captured + 32'd1;
        if (accept) begin
          written  <= written + 32'd1;
          dma_addr <= dma_addr + 32'd4;
        end
        if (done || (abort_pend && state != ST_ISSUE)) begin
          busy       <= 1'b0;
          abort_pend <= 1'b0;
        end else if (abort_cmd) begin
          abort_pend <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (push) fifo_mem[wr_ptr] <= {i_input_sample_right, i_input_sample_left};
  end

  // DMA write master: one word outstanding, request held stable until accepted.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state         <= ST_IDLE;
      o_dma_request <= 1'b0;
      o_dma_address <= '0;
      o_dma_wdata   <= '0;
    end else begin
      case (state)
        ST_IDLE: if (launch) begin
          o_dma_request <= 1'b1;
          o_dma_address <= dma_addr;
          o_dma_wdata   <= fifo_mem[rd_ptr];
          state         <= ST_ISSUE;
        end
        ST_ISSUE: if (i_dma_ready) begin
          o_dma_request <= 1'b0;
          state         <= ST_RELEASE;
        end
        ST_RELEASE: if (!i_dma_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_audio_capture_channel.sv
// Bench for audio_capture_channel: directed scenarios plus randomized captures,
// checked against a queue-based model of FIFO contents, counters and addresses.
module tb_audio_capture_channel;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        rw = 1'b0;
  logic [3:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        ready;
  logic        dma_req, dma_rw;
  logic [31:0] dma_addr, dma_wdata;
  logic        dma_ready = 1'b0;
  logic        s_clk = 1'b0;
  logic signed [15:0] s_l = '0, s_r = '0;

  audio_capture_channel #(.FIFO_DEPTH(DEPTH)) dut (
    .i_clock(clk), .i_reset(rst_n), .i_request(req), .i_rw(rw),
    .i_address(addr), .i_wdata(wdata), .o_rdata(rdata), .o_ready(ready),
    .o_dma_request(dma_req), .o_dma_rw(dma_rw), .o_dma_address(dma_addr),
    .o_dma_wdata(dma_wdata), .i_dma_ready(dma_ready),
    .i_input_sample_clock(s_clk), .i_input_sample_left(s_l),
    .i_input_sample_right(s_r)
  );

  always #5 clk = ~clk;

  int n_total = 0, n_pass = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m_reg0 = '0, m_n = '0, m_captured = '0, m_written = '0, m_addr = '0;
  bit m_busy = 0, m_ovf = 0, m_abort_hold = 0;
  int accepted = 0;
  bit bus_en = 1;
  int bus_lat = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] exp_reg2();
    logic e;
    e = m_abort_hold || (exp_q.size() == 0);
    return {29'd0, e, m_ovf, m_busy};
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    m_reg0 = '0; m_n = '0; m_captured = '0; m_written = '0; m_addr = '0;
    m_busy = 0; m_ovf = 0; m_abort_hold = 0;
  endfunction

  task automatic cpu_access(input bit w, input logic [3:0] a, input logic [31:0] d,
                            output logic [31:0] rd);
    int t;
    @(negedge clk);
    req = 1'b1; rw = w; addr = a; wdata = d;
    t = 0;
    do begin @(negedge clk); t++; end while (!ready && t < 20);
    check("cpu_ack", {31'd0, ready}, 32'd1);
    rd = rdata;
    req = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (ready && t < 20);
  endtask

  task automatic cpu_write(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] dummy, f;
    cpu_access(1'b1, a, d, dummy);
    case (a)
      4'd0: if (!m_busy) m_reg0 = d;
      4'd1: if (d != 0 && !m_busy) begin
        m_busy = 1; m_n = d; m_captured = 0; m_written = 0;
        exp_q.delete(); m_addr = m_reg0; m_abort_hold = 0;
      end
      4'd2: begin
        if (d[1]) m_ovf = 0;
        if (d[0] && m_busy) begin
          if (exp_q.size() > 0) begin
            f = exp_q[0]; exp_q.delete(); exp_q.push_back(f); m_abort_hold = 1;
          end else m_busy = 0;
        end
      end
      default: ;
    endcase
  endtask

  task automatic cpu_read(input logic [3:0] a, input string tag);
    logic [31:0] rd, e;
    cpu_access(1'b0, a, 32'd0, rd);
    case (a)
      4'd0: e = m_reg0;
      4'd1: e = m_n - m_written;
      4'd2: e = exp_reg2();
      default: e = 32'd0;
    endcase
    check(tag, rd, e);
  endtask

  task automatic strobe(input logic [15:0] l, input logic [15:0] r, input int gap);
    @(negedge clk);
    s_clk = 1'b1; s_l = l; s_r = r;
    if (m_busy && !m_abort_hold && m_captured < m_n) begin
      if (exp_q.size() < DEPTH) begin exp_q.push_back({r, l}); m_captured++; end
      else m_ovf = 1;
    end
    @(negedge clk);
    s_clk = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_accepts(input int target, input string tag);
    int t;
    t = 0;
    while (accepted < target && t < 2000) begin @(negedge clk); t++; end
    repeat (4) @(negedge clk);
    check(tag, accepted, target);
  endtask

  // Bus responder: grants after bus_lat stall cycles, checks hold stability and contents.
  initial begin
    bit hold;
    int w;
    logic [31:0] ha, hd, f;
    hold = 0; w = 0; ha = '0; hd = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin dma_ready = 1'b0; hold = 0; continue; end
      if (dma_ready) dma_ready = 1'b0;
      else if (dma_req) begin
        if (!hold) begin hold = 1; ha = dma_addr; hd = dma_wdata; w = 0; end
        else begin
          check("dma_addr_stable", dma_addr, ha);
          check("dma_data_stable", dma_wdata, hd);
          w++;
        end
        if (bus_en && w >= bus_lat) begin
          dma_ready = 1'b1; hold = 0;
          if (exp_q.size() == 0) check("dma_unexpected_req", {31'd0, dma_req}, 32'd0);
          else begin
            f = exp_q.pop_front();
            check("dma_wdata", dma_wdata, f);
            check("dma_addr", dma_addr, m_addr);
            m_addr += 32'd4; m_written++; accepted++;
            if (m_abort_hold) begin m_abort_hold = 0; m_busy = 0; end
            else if (m_written == m_n) m_busy = 0;
          end
        end
      end else hold = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, cnt;
    logic [31:0] base;
    repeat (3) @(negedge clk);
    check("rst_dma_req", {31'd0, dma_req}, 32'd0);
    check("rst_dma_rw", {31'd0, dma_rw}, 32'd1);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_dma_addr", dma_addr, 32'd0);
    check("rst_dma_wdata", dma_wdata, 32'd0);
    rst_n = 1'b1;
    cpu_read(4'd2, "rst_reg2");
    cpu_read(4'd1, "rst_reg1");
    cpu_read(4'd0, "rst_reg0");
    cpu_read(4'd9, "unmapped_read");

    // Basic capture
    cpu_write(4'd0, 32'h1000);
    cpu_read(4'd0, "basic_reg0");
    cpu_write(4'd1, 32'd4);
    accepted = 0;
    for (int i = 1; i <= 4; i++) strobe(16'(i), 16'(32'h8000 + i), 8);
    wait_accepts(4, "basic_writes");
    cpu_read(4'd2, "basic_reg2");
    cpu_read(4'd1, "basic_reg1");

    // Overflow with stalled bus
    bus_en = 0;
    cpu_write(4'd0, 32'h2000);
    cpu_write(4'd1, 32'd32);
    accepted = 0;
    for (int i = 0; i < 20; i++) strobe(16'($urandom), 16'($urandom), 2);
    cpu_read(4'd2, "ovf_reg2_set");
    cpu_read(4'd1, "ovf_reg1");
    cpu_write(4'd2, 32'h2);
    cpu_read(4'd2, "ovf_reg2_clear");
    bus_en = 1;
    wait_accepts(16, "ovf_stored");
    cpu_read(4'd1, "ovf_reg1_after");
    cpu_write(4'd2, 32'h1);
    repeat (4) @(negedge clk);
    cpu_read(4'd2, "ovf_abort_reg2");

    // Stalled bus, 5-cycle grant latency
    bus_lat = 5;
    cpu_write(4'd0, 32'h3000);
    cpu_write(4'd1, 32'd3);
    accepted = 0;
    for (int i = 0; i < 3; i++) strobe(16'($urandom), 16'($urandom), 3);
    wait_accepts(3, "stall_writes");
    cpu_read(4'd2, "stall_reg2");
    bus_lat = 0;

    // Extra strobes beyond N
    cpu_write(4'd0, 32'h4000);
    cpu_write(4'd1, 32'd2);
    accepted = 0;
    for (int i = 0; i < 5; i++) strobe(16'($urandom), 16'($urandom), 8);
    wait_accepts(2, "extra_writes");
    repeat (20) @(negedge clk);
    check("extra_no_more", accepted, 32'd2);
    cpu_read(4'd2, "extra_reg2");

    // Abort while a transfer is in flight
    bus_en = 0;
    cpu_write(4'd0, 32'h5000);
    cpu_write(4'd1, 32'd4);
    accepted = 0;
    for (int i = 0; i < 3; i++) strobe(16'($urandom), 16'($urandom), 2);
    repeat (4) @(negedge clk);
    check("abort_inflight_req", {31'd0, dma_req}, 32'd1);
    check("abort_inflight_addr", dma_addr, m_addr);
    cpu_write(4'd2, 32'h1);
    cpu_read(4'd2, "abort_pending_reg2");
    bus_en = 1;
    wait_accepts(1, "abort_inflight_done");
    cpu_read(4'd2, "abort_reg2");
    cpu_write(4'd1, 32'd2);
    accepted = 0;
    for (int i = 0; i < 2; i++) strobe(16'($urandom), 16'($urandom), 8);
    wait_accepts(2, "restart_writes");
    cpu_read(4'd2, "restart_reg2");

    // Randomized captures, the last one wrapping the 32-bit address
    for (int r = 0; r < 6; r++) begin
      base = (r == 5) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      n = (r == 5) ? 4 : int'($urandom_range(1, 8));
      cnt = n + int'($urandom_range(0, 2));
      bus_lat = int'($urandom_range(0, 4));
      cpu_write(4'd0, base);
      cpu_write(4'd1, 32'(n));
      accepted = 0;
      for (int i = 0; i < cnt; i++)
        strobe(16'($urandom), 16'($urandom), int'($urandom_range(9, 14)));
      wait_accepts(n, "rand_writes");
      cpu_read(4'd2, "rand_reg2");
      cpu_read(4'd1, "rand_reg1");
    end
    bus_lat = 0;

    // Asynchronous reset while a request is in flight
    bus_en = 0;
    cpu_write(4'd0, 32'h7000);
    cpu_write(4'd1, 32'd2);
    strobe(16'h1234, 16'h5678, 3);
    check("prereset_req", {31'd0, dma_req}, 32'd1);
    @(negedge clk);
    req = 1'b1; rw = 1'b0; addr = 4'd0;
    @(posedge clk);
    #1;
    check("prereset_ready", {31'd0, ready}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_dma_req", {31'd0, dma_req}, 32'd0);
    check("async_rst_ready", {31'd0, ready}, 32'd0);
    check("async_rst_rdata", rdata, 32'd0);
    req = 1'b0;
    model_reset();
    bus_en = 1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cpu_read(4'd2, "post_rst_reg2");
    cpu_read(4'd0, "post_rst_reg0");
    cpu_read(4'd1, "post_rst_reg1");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/audio_capture_channel.md
Name: audio_capture_channel

Overview:
- Single stereo audio capture (record) channel; the write-direction counterpart of the DMA-read playback channels.
- Samples arrive on a sample-clock strobe and are packed as {right,left} into 32-bit words. They are buffered in an internal FIFO and written to memory through a DMA write master.
- Programmed over the standard 4-bit-address CPU register interface.
- Sits beside the audio playback controller on the peripheral bus. Its DMA master goes to the same memory arbiter.

Parameters:
- FIFO_DEPTH, 16, capture FIFO depth in stereo words; power of two, minimum 2.

Ports:
- i_clock  in  1  system clock; all logic on its rising edge.
- i_reset  in  1  reset, asynchronous assert, active-low (0 = reset).
- i_request  in  1  CPU access request; held until o_ready is seen.
- i_rw  in  1  1 = write, 0 = read.
- i_address  in  4  register index.
- i_wdata  in  32  CPU write data.
- o_rdata  out  32  CPU read data, valid while o_ready = 1.
- o_ready  out  1  CPU access complete.
- o_dma_request  out  1  DMA write request.
- o_dma_rw  out  1  constant 1 (write).
- o_dma_address  out  32  DMA byte address.
- o_dma_wdata  out  32  DMA write data, {right[15:0], left[15:0]}.
- i_dma_ready  in  1  DMA transfer accepted.
- i_input_sample_clock  in  1  one-cycle strobe, one stereo sample per pulse.
- i_input_sample_left  in  16  signed left sample; valid with the strobe.
- i_input_sample_right  in  16  signed right sample; valid with the strobe.

Behaviour:
- Reset (i_reset = 0, any time, asynchronous): all outputs 0 except o_dma_rw = 1. FIFO emptied, busy = 0, overflow = 0, counters and address = 0. A DMA request in flight is dropped without completion.
- CPU handshake: an access is served when i_request = 1 and o_ready = 0. o_ready rises one cycle later and stays 1 until i_request = 0. It falls the cycle after i_request falls. Every address completes; unmapped reads return 0.
- Register 0, R/W: start address. Writes ignored while busy.
- Register 1, write: sample count N.
  - If N != 0 and not busy: busy = 1, captured = 0, written = 0, FIFO flushed, DMA address = register 0.
  - If N = 0 or busy: no effect.
- Register 1, read: remaining words, N - written.
- Register 2, read: {29'b0, fifo_empty, overflow, busy}.
- Register 2, write: bit1 = 1 clears overflow. bit0 = 1 aborts: capture stops immediately, FIFO flushed, busy drops once any in-flight DMA transfer completes.
- Capture:
  - On an i_input_sample_clock pulse with busy = 1 and captured < N: if the FIFO is not full, push {right,left} and increment captured.
  - If the FIFO is full: the sample is dropped, overflow is set (sticky), and captured is not incremented.
  - Strobes while not busy, or with captured = N, are ignored.
  - A push and a pop in the same cycle are both legal; occupancy is unchanged.
- DMA FSM:
  - IDLE: if FIFO not empty and i_dma_ready = 0, present the FIFO head on o_dma_wdata, load o_dma_address, set o_dma_request = 1, go to ISSUE.
  - ISSUE: hold request, address and data stable until i_dma_ready = 1. On that cycle: pop FIFO, written++, address += 4, request drops next cycle, go to RELEASE.
  - RELEASE: wait for i_dma_ready = 0, then go to IDLE.
  - Minimum 3 cycles per word with a zero-wait bus.
- Completion: busy clears the cycle after the transfer that makes written = N.
- Widths and wrap: address is 32 bits and wraps modulo 2^32. Counters are 32 bits.

Test Plan:
- Basic capture: write reg0 = 0x1000, reg1 = 4. Pulse the strobe 4 times with L = 0x0001..0x0004, R = 0x8001..0x8004, zero-wait bus. Required: 4 DMA writes to 0x1000, 0x1004, 0x1008, 0x100C with wdata 0x80010001..0x80040004; reg2 reads 0x4 afterwards; reg1 read = 0.
- Overflow: FIFO_DEPTH = 16, bus i_dma_ready held 0, N = 32, 20 strobes. Required: 16 samples stored, reg2 bit1 = 1; writing reg2 = 0x2 clears it.
- Stalled bus: i_dma_ready delayed 5 cycles. Required: o_dma_request, address and data stable throughout, exactly one pop per accepted transfer.
- Extra strobes: N = 2, 5 strobes. Required: exactly 2 DMA writes, busy = 0, no overflow.
- Abort mid-transfer: abort while in ISSUE. Required: the in-flight write completes, busy drops the cycle after, FIFO empty; a subsequent reg1 write restarts capture from reg0.
- Async reset during ISSUE: assert i_reset = 0 mid-cycle. Required: o_dma_request = 0 and o_ready = 0 immediately, without waiting for a clock edge; reg2 reads 0x4 after release.
